// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at dispatch, captures writeback results,
// and retires in program order into the register file, flushing on a faulting head.
module reorder_buffer #(
  parameter int unsigned ROB_ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_dest,
  input  logic [DATA_WIDTH-1:0]     alloc_pc,
  output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
  output logic                      full,
  output logic                      empty,
  input  logic                      wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb_id,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      wb_exc,
  input  logic [ROB_ADDR_WIDTH-1:0] read_id_1,
  input  logic [ROB_ADDR_WIDTH-1:0] read_id_2,
  output logic                      read_done_1,
  output logic                      read_done_2,
  output logic [DATA_WIDTH-1:0]     read_data_1,
  output logic [DATA_WIDTH-1:0]     read_data_2,
  output logic                      rf_write_en,
  output logic                      rf_write_restore,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic                      rf_write_is_ref,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      exc_valid,
  output logic [DATA_WIDTH-1:0]     exc_pc
);

  localparam int unsigned DEPTH = 2 ** ROB_ADDR_WIDTH;
  localparam int unsigned CNT_W = ROB_ADDR_WIDTH + 1;

  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0]          done_q, done_d;
  logic [DEPTH-1:0]          exc_q, exc_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] dest_d [DEPTH];
  logic [DATA_WIDTH-1:0]     pc_q [DEPTH];
  logic [DATA_WIDTH-1:0]     pc_d [DEPTH];
  logic [DATA_WIDTH-1:0]     value_q [DEPTH];
  logic [DATA_WIDTH-1:0]     value_d [DEPTH];

  logic [ROB_ADDR_WIDTH-1:0] head_q, head_d;
  logic [ROB_ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;

  logic                      rf_write_en_q, rf_write_en_d;
  logic                      rf_write_restore_q, rf_write_restore_d;
  logic [REG_ADDR_WIDTH-1:0] rf_write_addr_q, rf_write_addr_d;
  logic                      rf_write_is_ref_q, rf_write_is_ref_d;
  logic [DATA_WIDTH-1:0]     rf_write_data_q, rf_write_data_d;
  logic                      exc_valid_q, exc_valid_d;
  logic [DATA_WIDTH-1:0]     exc_pc_q, exc_pc_d;

  logic head_ready, commit_ok, flush, alloc_ok, wb_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign alloc_id = tail_q;

  // Head is retired on pre-edge state; a faulting head flushes instead.
  assign head_ready = valid_q[head_q] && done_q[head_q];
  assign commit_ok  = head_ready && !exc_q[head_q];
  assign flush      = head_ready && exc_q[head_q];
  assign alloc_ok   = alloc_en && !full && !flush;
  assign wb_ok      = wb_en && valid_q[wb_id] && !flush;

  // Operand lookup with same-cycle writeback bypass.
  always_comb begin
    read_done_1 = 1'b0;
    read_data_1 = '0;
    if (wb_en && (wb_id == read_id_1)) begin
      read_done_1 = 1'b1;
      read_data_1 = wb_data;
    end else if (valid_q[read_id_1] && done_q[read_id_1]) begin
      read_done_1 = 1'b1;
      read_data_1 = value_q[read_id_1];
    end
  end

  always_comb begin
    read_done_2 = 1'b0;
    read_data_2 = '0;
    if (wb_en && (wb_id == read_id_2)) begin
      read_done_2 = 1'b1;
      read_data_2 = wb_data;
    end else if (valid_q[read_id_2] && done_q[read_id_2]) begin
      read_done_2 = 1'b1;
      read_data_2 = value_q[read_id_2];
    end
  end

  // Entry and pointer next state; allocation is applied last so it wins.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    dest_d  = dest_q;
    pc_d    = pc_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (commit_ok) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ROB_ADDR_WIDTH'(1);
    end

    if (wb_ok) begin
      done_d[wb_id]  = 1'b1;
      exc_d[wb_id]   = wb_exc;
      value_d[wb_id] = wb_data;
    end

    if (alloc_ok) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      exc_d[tail_q]   = 1'b0;
      dest_d[tail_q]  = alloc_dest;
      pc_d[tail_q]    = alloc_pc;
      tail_d          = tail_q + ROB_ADDR_WIDTH'(1);
    end

    case ({alloc_ok, commit_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Register-file and exception strobes: zero unless a commit or flush happens.
  always_comb begin
    rf_write_en_d      = 1'b0;
    rf_write_restore_d = 1'b0;
    rf_write_addr_d    = '0;
    rf_write_is_ref_d  = 1'b0;
    rf_write_data_d    = '0;
    exc_valid_d        = 1'b0;
    exc_pc_d           = '0;
    if (commit_ok) begin
      rf_write_en_d   = (dest_q[head_q] != '0);
      rf_write_addr_d = dest_q[head_q];
      rf_write_data_d = value_q[head_q];
    end
    if (flush) begin
      rf_write_restore_d = 1'b1;
      exc_valid_d        = 1'b1;
      exc_pc_d           = pc_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q            <= '0;
      done_q             <= '0;
      exc_q              <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      rf_write_en_q      <= 1'b0;
      rf_write_restore_q <= 1'b0;
      rf_write_addr_q    <= '0;
      rf_write_is_ref_q  <= 1'b0;
      rf_write_data_q    <= '0;
      exc_valid_q        <= 1'b0;
      exc_pc_q           <= '0;
    end else begin
      valid_q            <= valid_d;
      done_q             <= done_d;
      exc_q              <= exc_d;
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      rf_write_en_q      <= rf_write_en_d;
      rf_write_restore_q <= rf_write_restore_d;
      rf_write_addr_q    <= rf_write_addr_d;
      rf_write_is_ref_q  <= rf_write_is_ref_d;
      rf_write_data_q    <= rf_write_data_d;
      exc_valid_q        <= exc_valid_d;
      exc_pc_q           <= exc_pc_d;
    end
  end

  // Payload storage is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    dest_q  <= dest_d;
    pc_q    <= pc_d;
    value_q <= value_d;
  end

  assign rf_write_en      = rf_write_en_q;
  assign rf_write_restore = rf_write_restore_q;
  assign rf_write_addr    = rf_write_addr_q;
  assign rf_write_is_ref  = rf_write_is_ref_q;
  assign rf_write_data    = rf_write_data_q;
  assign exc_valid        = exc_valid_q;
  assign exc_pc           = exc_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit, full/wrap, flush, bypass, reset.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        alloc_en;
  logic [4:0]  alloc_dest;
  logic [31:0] alloc_pc;
  logic [3:0]  alloc_id;
  logic        full;
  logic        empty;
  logic        wb_en;
  logic [3:0]  wb_id;
  logic [31:0] wb_data;
  logic        wb_exc;
  logic [3:0]  read_id_1;
  logic [3:0]  read_id_2;
  logic        read_done_1;
  logic        read_done_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic        rf_write_en;
  logic        rf_write_restore;
  logic [4:0]  rf_write_addr;
  logic        rf_write_is_ref;
  logic [31:0] rf_write_data;
  logic        exc_valid;
  logic [31:0] exc_pc;

  int total = 0;
  int bad   = 0;

  reorder_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_en         (alloc_en),
    .alloc_dest       (alloc_dest),
    .alloc_pc         (alloc_pc),
    .alloc_id         (alloc_id),
    .full             (full),
    .empty            (empty),
    .wb_en            (wb_en),
    .wb_id            (wb_id),
    .wb_data          (wb_data),
    .wb_exc           (wb_exc),
    .read_id_1        (read_id_1),
    .read_id_2        (read_id_2),
    .read_done_1      (read_done_1),
    .read_done_2      (read_done_2),
    .read_data_1      (read_data_1),
    .read_data_2      (read_data_2),
    .rf_write_en      (rf_write_en),
    .rf_write_restore (rf_write_restore),
    .rf_write_addr    (rf_write_addr),
    .rf_write_is_ref  (rf_write_is_ref),
    .rf_write_data    (rf_write_data),
    .exc_valid        (exc_valid),
    .exc_pc           (exc_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [3:0] id, input logic [31:0] data, input logic exc);
    wb_en   = 1'b1;
    wb_id   = id;
    wb_data = data;
    wb_exc  = exc;
  endtask

  task automatic wb_off();
    wb_en  = 1'b0;
    wb_exc = 1'b0;
  endtask

  initial begin
    rst = 1'b0; alloc_en = 1'b0; alloc_dest = '0; alloc_pc = '0;
    wb_en = 1'b0; wb_id = '0; wb_data = '0; wb_exc = 1'b0;
    read_id_1 = '0; read_id_2 = '0;
    tick();
    tick();
    chk("rst_empty",   32'(empty), 32'd1);
    chk("rst_full",    32'(full), 32'd0);
    chk("rst_id",      32'(alloc_id), 32'd0);
    chk("rst_wen",     32'(rf_write_en), 32'd0);
    chk("rst_restore", 32'(rf_write_restore), 32'd0);
    chk("rst_excv",    32'(exc_valid), 32'd0);
    chk("rst_excpc",   exc_pc, 32'd0);
    rst = 1'b1;
    tick();

    // Three allocations, dest 1..3
    for (int i = 0; i < 3; i++) begin
      alloc_en = 1'b1; alloc_dest = 5'(i + 1); alloc_pc = 32'h1000 + 32'(4 * i);
      #1;
      chk("alloc_id_a", 32'(alloc_id), 32'(i));
      tick();
    end
    alloc_en = 1'b0;
    chk("a3_empty", 32'(empty), 32'd0);
    chk("a3_tail",  32'(alloc_id), 32'd3);
    chk("a3_wen",   32'(rf_write_en), 32'd0);

    // Out-of-order writeback 2,0,1; commits appear in order 0,1,2
    wb(4'd2, 32'h22, 1'b0); tick();
    chk("wb2_wen", 32'(rf_write_en), 32'd0);
    wb(4'd0, 32'h00, 1'b0); tick();
    chk("wb0_wen", 32'(rf_write_en), 32'd0);
    wb(4'd1, 32'h11, 1'b0); tick();
    chk("c0_wen",  32'(rf_write_en), 32'd1);
    chk("c0_addr", 32'(rf_write_addr), 32'd1);
    chk("c0_data", rf_write_data, 32'h00);
    chk("c0_ref",  32'(rf_write_is_ref), 32'd0);
    wb_off(); tick();
    chk("c1_wen",  32'(rf_write_en), 32'd1);
    chk("c1_addr", 32'(rf_write_addr), 32'd2);
    chk("c1_data", rf_write_data, 32'h11);
    tick();
    chk("c2_wen",  32'(rf_write_en), 32'd1);
    chk("c2_addr", 32'(rf_write_addr), 32'd3);
    chk("c2_data", rf_write_data, 32'h22);
    chk("c2_ref",  32'(rf_write_is_ref), 32'd0);
    tick();
    chk("c3_wen",   32'(rf_write_en), 32'd0);
    chk("c3_empty", 32'(empty), 32'd1);

    // Ids 3,4,5 with dests 4,0,6; operand bypass and dest-0 retirement
    alloc_en = 1'b1; alloc_dest = 5'd4; alloc_pc = 32'h2000; tick();
    alloc_dest = 5'd0; tick();
    alloc_dest = 5'd6; tick();
    alloc_en = 1'b0;
    read_id_1 = 4'd5; read_id_2 = 4'd4;
    #1;
    chk("rd_pend_done", 32'(read_done_1), 32'd0);
    chk("rd_pend_data", read_data_1, 32'd0);
    wb(4'd5, 32'hABCD, 1'b0);
    #1;
    chk("rd_byp_done",  32'(read_done_1), 32'd1);
    chk("rd_byp_data",  read_data_1, 32'hABCD);
    chk("rd2_pend",     32'(read_done_2), 32'd0);
    chk("rd2_pend_dat", read_data_2, 32'd0);
    tick();
    wb(4'd3, 32'h33, 1'b0);
    #1;
    chk("rd_store_done", 32'(read_done_1), 32'd1);
    chk("rd_store_data", read_data_1, 32'hABCD);
    tick();
    wb(4'd4, 32'h44, 1'b0); tick();
    chk("c3x_wen",  32'(rf_write_en), 32'd1);
    chk("c3x_addr", 32'(rf_write_addr), 32'd4);
    chk("c3x_data", rf_write_data, 32'h33);
    wb_off(); tick();
    chk("dest0_wen", 32'(rf_write_en), 32'd0);
    tick();
    chk("c5_wen",  32'(rf_write_en), 32'd1);
    chk("c5_addr", 32'(rf_write_addr), 32'd6);
    chk("c5_data", rf_write_data, 32'hABCD);
    tick();
    chk("c5_empty", 32'(empty), 32'd1);
    chk("c5_tail",  32'(alloc_id), 32'd6);

    // Fill all 16 entries starting at id 6, wrapping through 15 -> 0
    for (int i = 0; i < 16; i++) begin
      alloc_en = 1'b1; alloc_dest = 5'(i + 1); alloc_pc = 32'h80000004 + 32'(4 * i);
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_tail", 32'(alloc_id), 32'd6);
    tick();
    chk("ovf_tail", 32'(alloc_id), 32'd6);
    chk("ovf_full", 32'(full), 32'd1);
    alloc_en = 1'b0;
    wb(4'd6, 32'h66, 1'b0); tick();
    wb_off();
    alloc_en = 1'b1; alloc_dest = 5'd20; alloc_pc = 32'h3000;
    tick();
    chk("fc_wen",  32'(rf_write_en), 32'd1);
    chk("fc_addr", 32'(rf_write_addr), 32'd1);
    chk("fc_full", 32'(full), 32'd0);
    chk("fc_tail", 32'(alloc_id), 32'd6);
    tick();
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_tail", 32'(alloc_id), 32'd7);
    alloc_en = 1'b0;
    wb(4'd7, 32'h77, 1'b0); tick();
    wb_off(); tick();
    chk("c7_full", 32'(full), 32'd0);
    wb(4'd8, 32'h88, 1'b0); tick();
    wb_off();
    alloc_en = 1'b1; alloc_dest = 5'd21; alloc_pc = 32'h3004;
    tick();
    chk("sim_wen",  32'(rf_write_en), 32'd1);
    chk("sim_addr", 32'(rf_write_addr), 32'd3);
    chk("sim_full", 32'(full), 32'd0);
    chk("sim_tail", 32'(alloc_id), 32'd8);
    tick();
    chk("sim2_full", 32'(full), 32'd1);
    chk("sim2_tail", 32'(alloc_id), 32'd9);
    alloc_en = 1'b0;

    // Faulting head (id 9, pc 0x80000010) flushes; alloc/wb in flush edge dropped
    wb(4'd9, 32'hDEAD, 1'b1); tick();
    wb(4'd10, 32'hBEEF, 1'b0);
    alloc_en = 1'b1; alloc_dest = 5'd7; alloc_pc = 32'h4000;
    tick();
    chk("fl_restore", 32'(rf_write_restore), 32'd1);
    chk("fl_excv",    32'(exc_valid), 32'd1);
    chk("fl_excpc",   exc_pc, 32'h80000010);
    chk("fl_wen",     32'(rf_write_en), 32'd0);
    chk("fl_empty",   32'(empty), 32'd1);
    chk("fl_tail",    32'(alloc_id), 32'd0);
    alloc_en = 1'b0; wb_off();
    tick();
    chk("fl1_restore", 32'(rf_write_restore), 32'd0);
    chk("fl1_excv",    32'(exc_valid), 32'd0);
    chk("fl1_excpc",   exc_pc, 32'd0);
    alloc_en = 1'b1; alloc_dest = 5'd9; alloc_pc = 32'h5000;
    #1;
    chk("pf_id", 32'(alloc_id), 32'd0);
    tick();
    chk("pf_tail",  32'(alloc_id), 32'd1);
    chk("pf_empty", 32'(empty), 32'd0);

    // Mid-stream reset discards a head that would otherwise commit
    alloc_dest = 5'd10; tick();
    alloc_en = 1'b0;
    wb(4'd0, 32'h99, 1'b0); tick();
    wb(4'd1, 32'h98, 1'b0);
    rst = 1'b0;
    tick();
    chk("mr_wen",   32'(rf_write_en), 32'd0);
    chk("mr_data",  rf_write_data, 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_tail",  32'(alloc_id), 32'd0);
    wb_off();
    rst = 1'b1;
    read_id_1 = 4'd0;
    tick();
    chk("mr2_wen",  32'(rf_write_en), 32'd0);
    chk("mr2_read", 32'(read_done_1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
